// File: rtl/exe_stage.sv
// Execute stage: single-cycle ALU, branch resolution and a
// multi-cycle unsigned MUL/DIVU unit that stalls the front end.
module exe_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Val1,
    input  logic [31:0] Val2,
    input  logic [31:0] Reg2,
    input  logic [31:0] PC_in,
    input  logic [3:0]  EXE_CMD,
    input  logic [1:0]  br_type,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic        WB_EN,
    input  logic [4:0]  Dest,
    output logic [31:0] ALU_result,
    output logic [31:0] Reg2_out,
    output logic [4:0]  Dest_out,
    output logic        MEM_R_EN_out,
    output logic        MEM_W_EN_out,
    output logic        WB_EN_out,
    output logic        Br_taken,
    output logic [31:0] Br_addr,
    output logic        Stall
);

    localparam logic [3:0] CMD_ADD  = 4'b0000;
    localparam logic [3:0] CMD_SUB  = 4'b0010;
    localparam logic [3:0] CMD_AND  = 4'b0100;
    localparam logic [3:0] CMD_OR   = 4'b0101;
    localparam logic [3:0] CMD_NOR  = 4'b0110;
    localparam logic [3:0] CMD_XOR  = 4'b0111;
    localparam logic [3:0] CMD_SLL  = 4'b1000;
    localparam logic [3:0] CMD_SRA  = 4'b1001;
    localparam logic [3:0] CMD_SRL  = 4'b1010;
    localparam logic [3:0] CMD_MUL  = 4'b1100;
    localparam logic [3:0] CMD_DIVU = 4'b1101;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEZ  = 2'b01;
    localparam logic [1:0] BR_BNE  = 2'b10;
    localparam logic [1:0] BR_JMP  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] res_q, res_d;
    logic        div_q, div_d;

    logic        is_mc;
    logic        stall_int;
    logic [31:0] alu_comb;
    logic        br_cond;
    logic [63:0] mul_step;
    logic [32:0] div_t;
    logic [32:0] div_sub;
    logic [63:0] div_step;

    assign is_mc = (EXE_CMD == CMD_MUL) || (EXE_CMD == CMD_DIVU);

    always_comb begin
        alu_comb = 32'd0;
        case (EXE_CMD)
            CMD_ADD: alu_comb = Val1 + Val2;
            CMD_SUB: alu_comb = Val1 - Val2;
            CMD_AND: alu_comb = Val1 & Val2;
            CMD_OR:  alu_comb = Val1 | Val2;
            CMD_NOR: alu_comb = ~(Val1 | Val2);
            CMD_XOR: alu_comb = Val1 ^ Val2;
            CMD_SLL: alu_comb = Val1 << Val2[4:0];
            CMD_SRA: alu_comb = $signed(Val1) >>> Val2[4:0];
            CMD_SRL: alu_comb = Val1 >> Val2[4:0];
            default: alu_comb = 32'd0;
        endcase
    end

    always_comb begin
        br_cond = 1'b0;
        case (br_type)
            BR_NONE: br_cond = 1'b0;
            BR_BEZ:  br_cond = (Val1 == 32'd0);
            BR_BNE:  br_cond = (Val1 != Reg2);
            BR_JMP:  br_cond = 1'b1;
            default: br_cond = 1'b0;
        endcase
    end

    // Shift-add: add the multiplicand shifted by the current bit index.
    assign mul_step = b_q[cnt_q] ? acc_q + ({32'd0, a_q} << cnt_q)
                                 : acc_q;

    // Restoring division: acc holds {remainder, quotient so far}.
    assign div_t    = {acc_q[63:32], a_q[5'd31 - cnt_q]};
    assign div_sub  = div_t - {1'b0, b_q};
    assign div_step = (div_t >= {1'b0, b_q})
                    ? {div_sub[31:0], acc_q[30:0], 1'b1}
                    : {div_t[31:0], acc_q[30:0], 1'b0};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        res_d     = res_q;
        div_d     = div_q;
        stall_int = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_mc) begin
                    a_d       = Val1;
                    b_d       = Val2;
                    acc_d     = 64'd0;
                    cnt_d     = 5'd0;
                    div_d     = (EXE_CMD == CMD_DIVU);
                    state_d   = BUSY;
                    stall_int = 1'b1;
                end
            end
            BUSY: begin
                stall_int = 1'b1;
                acc_d     = div_q ? div_step : mul_step;
                cnt_d     = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    res_d   = acc_d[31:0];
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            acc_q   <= 64'd0;
            res_q   <= 32'd0;
            div_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            div_q   <= div_d;
        end
    end

    assign Stall        = stall_int & ~rst;
    assign ALU_result   = (state_q == DONE) ? res_q : alu_comb;
    assign Br_addr      = PC_in + {Val2[29:0], 2'b00};
    assign Br_taken     = br_cond & ~stall_int & ~rst;
    assign MEM_R_EN_out = MEM_R_EN & ~stall_int & ~rst;
    assign MEM_W_EN_out = MEM_W_EN & ~stall_int & ~rst;
    assign WB_EN_out    = WB_EN & ~stall_int & ~rst;
    assign Reg2_out     = Reg2;
    assign Dest_out     = Dest;

endmodule

// File: tb/tb_exe_stage.sv
// Directed-vector bench for exe_stage: ALU/branch table plus
// multi-cycle MUL/DIVU, back-to-back and reset-abort sequences.
module tb_exe_stage;

    logic        clk;
    logic        rst;
    logic [31:0] Val1, Val2, Reg2, PC_in;
    logic [3:0]  EXE_CMD;
    logic [1:0]  br_type;
    logic        MEM_R_EN, MEM_W_EN, WB_EN;
    logic [4:0]  Dest;
    logic [31:0] ALU_result, Reg2_out, Br_addr;
    logic [4:0]  Dest_out;
    logic        MEM_R_EN_out, MEM_W_EN_out, WB_EN_out;
    logic        Br_taken, Stall;

    int n_chk;
    int n_fail;

    exe_stage dut (
        .clk          (clk),
        .rst          (rst),
        .Val1         (Val1),
        .Val2         (Val2),
        .Reg2         (Reg2),
        .PC_in        (PC_in),
        .EXE_CMD      (EXE_CMD),
        .br_type      (br_type),
        .MEM_R_EN     (MEM_R_EN),
        .MEM_W_EN     (MEM_W_EN),
        .WB_EN        (WB_EN),
        .Dest         (Dest),
        .ALU_result   (ALU_result),
        .Reg2_out     (Reg2_out),
        .Dest_out     (Dest_out),
        .MEM_R_EN_out (MEM_R_EN_out),
        .MEM_W_EN_out (MEM_W_EN_out),
        .WB_EN_out    (WB_EN_out),
        .Br_taken     (Br_taken),
        .Br_addr      (Br_addr),
        .Stall        (Stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cmd;
        logic [1:0]  br;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] r2;
        logic [31:0] pc;
        logic [31:0] alu;
        logic        bt;
        logic [31:0] ba;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h",
                     name, act, exp);
        end
    endtask

    // Caller sits #1 after a rising edge with the FSM in IDLE.
    task automatic run_mc(input logic [3:0] cmd, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int stalls;
        int bad_ctl;
        EXE_CMD  = cmd;
        br_type  = 2'b11;
        Val1     = a;
        Val2     = b;
        MEM_R_EN = 1'b1;
        MEM_W_EN = 1'b1;
        WB_EN    = 1'b1;
        #1;
        stalls  = 0;
        bad_ctl = 0;
        if (Stall) stalls++;
        if (WB_EN_out | MEM_R_EN_out | MEM_W_EN_out | Br_taken)
            bad_ctl++;
        for (int k = 1; k <= 33; k++) begin
            @(posedge clk);
            #1;
            if (k <= 32) begin
                if (Stall) stalls++;
                if (WB_EN_out | MEM_R_EN_out | MEM_W_EN_out | Br_taken)
                    bad_ctl++;
            end
        end
        check("mc_stall_cycles", stalls, 33);
        check("mc_bubble_ctl", bad_ctl, 0);
        check("mc_done_stall", {31'd0, Stall}, 32'd0);
        check("mc_done_result", ALU_result, exp);
        check("mc_done_wb", {31'd0, WB_EN_out}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        vecs[0]  = '{4'b0000, 2'b00, 32'hFFFFFFFF, 32'd2, 32'd0,
                     32'h0, 32'h00000001, 1'b0, 32'h8};
        vecs[1]  = '{4'b0010, 2'b00, 32'd5, 32'd7, 32'd0,
                     32'h0, 32'hFFFFFFFE, 1'b0, 32'h1C};
        vecs[2]  = '{4'b0100, 2'b00, 32'hF0F000FF, 32'h0FF00F0F, 32'd0,
                     32'h0, 32'h00F0000F, 1'b0, 32'h3FC03C3C};
        vecs[3]  = '{4'b0101, 2'b00, 32'hF0F000FF, 32'h0FF00F0F, 32'd0,
                     32'h0, 32'hFFF00FFF, 1'b0, 32'h3FC03C3C};
        vecs[4]  = '{4'b0110, 2'b00, 32'hF0F000FF, 32'h0FF00F0F, 32'd0,
                     32'h0, 32'h000FF000, 1'b0, 32'h3FC03C3C};
        vecs[5]  = '{4'b0111, 2'b00, 32'hF0F000FF, 32'h0FF00F0F, 32'd0,
                     32'h0, 32'hFF000FF0, 1'b0, 32'h3FC03C3C};
        vecs[6]  = '{4'b1000, 2'b00, 32'h00000001, 32'h0000003F, 32'd0,
                     32'h0, 32'h80000000, 1'b0, 32'hFC};
        vecs[7]  = '{4'b1001, 2'b00, 32'h80000000, 32'd4, 32'd0,
                     32'h0, 32'hF8000000, 1'b0, 32'h10};
        vecs[8]  = '{4'b1010, 2'b00, 32'h80000000, 32'd4, 32'd0,
                     32'h0, 32'h08000000, 1'b0, 32'h10};
        vecs[9]  = '{4'b0001, 2'b00, 32'h12345678, 32'd4, 32'd0,
                     32'h0, 32'h00000000, 1'b0, 32'h10};
        vecs[10] = '{4'b1111, 2'b00, 32'h12345678, 32'd4, 32'd0,
                     32'h0, 32'h00000000, 1'b0, 32'h10};
        vecs[11] = '{4'b0000, 2'b10, 32'd5, 32'd3, 32'd6,
                     32'h100, 32'd8, 1'b1, 32'h10C};
        vecs[12] = '{4'b0000, 2'b10, 32'd5, 32'd3, 32'd5,
                     32'h100, 32'd8, 1'b0, 32'h10C};
        vecs[13] = '{4'b0000, 2'b01, 32'd0, 32'hFFFFFFFF, 32'd9,
                     32'h100, 32'hFFFFFFFF, 1'b1, 32'hFC};
        vecs[14] = '{4'b0000, 2'b11, 32'd1, 32'd8, 32'd0,
                     32'hFFFFFFF0, 32'd9, 1'b1, 32'h10};
        vecs[15] = '{4'b0000, 2'b01, 32'd1, 32'd1, 32'd0,
                     32'h40, 32'd2, 1'b0, 32'h44};

        rst      = 1'b1;
        Val1     = 32'd3;
        Val2     = 32'd4;
        Reg2     = 32'hA5A5A5A5;
        PC_in    = 32'h0;
        EXE_CMD  = 4'b1100;
        br_type  = 2'b11;
        MEM_R_EN = 1'b1;
        MEM_W_EN = 1'b1;
        WB_EN    = 1'b1;
        Dest     = 5'd17;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", {31'd0, Stall}, 32'd0);
        check("rst_br_taken", {31'd0, Br_taken}, 32'd0);
        check("rst_ctl", {29'd0, MEM_R_EN_out, MEM_W_EN_out, WB_EN_out},
              32'd0);
        check("rst_reg2_out", Reg2_out, 32'hA5A5A5A5);
        check("rst_dest_out", {27'd0, Dest_out}, 32'd17);

        EXE_CMD = 4'b0000;
        br_type = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            EXE_CMD  = vecs[i].cmd;
            br_type  = vecs[i].br;
            Val1     = vecs[i].v1;
            Val2     = vecs[i].v2;
            Reg2     = vecs[i].r2;
            PC_in    = vecs[i].pc;
            WB_EN    = i[0];
            MEM_R_EN = i[1];
            MEM_W_EN = i[2];
            Dest     = i[4:0];
            #2;
            check($sformatf("v%0d_alu", i), ALU_result, vecs[i].alu);
            check($sformatf("v%0d_bt", i), {31'd0, Br_taken},
                  {31'd0, vecs[i].bt});
            check($sformatf("v%0d_ba", i), Br_addr, vecs[i].ba);
            check($sformatf("v%0d_stall", i), {31'd0, Stall}, 32'd0);
            check($sformatf("v%0d_ctl", i),
                  {29'd0, MEM_R_EN_out, MEM_W_EN_out, WB_EN_out},
                  {29'd0, i[1], i[2], i[0]});
            check($sformatf("v%0d_dest", i), {27'd0, Dest_out}, i);
            check($sformatf("v%0d_reg2", i), Reg2_out, vecs[i].r2);
            @(posedge clk);
            #1;
        end

        run_mc(4'b1100, 32'h00010000, 32'h00030001, 32'h00010000);
        EXE_CMD = 4'b0000;
        @(posedge clk);
        #1;
        run_mc(4'b1101, 32'd100, 32'd7, 32'd14);
        EXE_CMD = 4'b0000;
        @(posedge clk);
        #1;
        run_mc(4'b1101, 32'd100, 32'd0, 32'hFFFFFFFF);
        EXE_CMD = 4'b0000;
        @(posedge clk);
        #1;
        run_mc(4'b1101, 32'hFFFFFFFF, 32'd16, 32'h0FFFFFFF);
        EXE_CMD = 4'b0000;
        @(posedge clk);
        #1;

        run_mc(4'b1100, 32'd3, 32'd4, 32'd12);
        run_mc(4'b1100, 32'd5, 32'd6, 32'd30);
        EXE_CMD = 4'b0000;
        @(posedge clk);
        #1;

        EXE_CMD = 4'b1100;
        Val1    = 32'd9;
        Val2    = 32'd9;
        WB_EN   = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        check("abort_pre_stall", {31'd0, Stall}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort_stall", {31'd0, Stall}, 32'd0);
        check("abort_wb", {31'd0, WB_EN_out}, 32'd0);
        EXE_CMD = 4'b0000;
        Val1    = 32'd1;
        Val2    = 32'd1;
        #1;
        rst = 1'b0;
        #1;
        check("abort_idle_alu", ALU_result, 32'd2);
        check("abort_idle_stall", {31'd0, Stall}, 32'd0);
        @(posedge clk);
        #1;
        run_mc(4'b1100, 32'd2, 32'd2, 32'd4);
        EXE_CMD = 4'b0000;
        @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
